serdes_tx_word_feeder: RTL and testbench
========================================

Name: serdes_tx_word_feeder

Overview:
- Fabric-side upstream stage for the O_SERDES transmit primitive, clocked on the serializer fabric clock.
- Accepts parallel words over a valid/ready stream and buffers them in a small FIFO.
- Gates on a synchronized PLL lock, then sends a training burst, then streams data with idle fill.
- Drives the primitive's D, LOAD_WORD, OE_IN, PLL_LOCK and CHANNEL_BOND_SYNC_IN inputs.

Parameters:
WIDTH, 4, word width; must match the O_SERDES WIDTH (3-10)
FIFO_DEPTH, 4, buffer depth in words; power of 2, minimum 2
TRAIN_WORDS, 8, number of training words sent after lock; 1-255
TRAIN_PATTERN, 4'b1010, word driven during training (WIDTH bits)
IDLE_PATTERN, 4'b0000, word driven when the FIFO underruns (WIDTH bits)

Ports:
clk_in  input  1  fabric clock, same clock as O_SERDES CLK_IN
reset  input  1  asynchronous, active-low reset
pll_lock_raw  input  1  PLL lock; asynchronous to clk_in
s_data  input  WIDTH  stream word
s_valid  input  1  stream word valid
s_ready  output  1  FIFO can accept a word
d_out  output  WIDTH  to O_SERDES D
load_word  output  1  to O_SERDES LOAD_WORD
oe_in  output  1  to O_SERDES OE_IN
pll_lock_out  output  1  synchronized lock, to O_SERDES PLL_LOCK
bond_sync  output  1  to O_SERDES CHANNEL_BOND_SYNC_IN
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
train_done  output  1  high while in RUN

Behaviour:
- Reset values: all outputs 0 (d_out=0, load_word=0, oe_in=0, pll_lock_out=0, bond_sync=0, train_done=0, fifo_level=0). s_ready is 1 once reset is released.
- Lock synchronizer: 2-flop synchronizer on pll_lock_raw drives pll_lock_out. Lock rise or fall is visible 2 clk_in edges later.
- FSM states:
  - IDLE: pll_lock_out=0. Outputs oe_in=0, load_word=0, d_out=IDLE_PATTERN. Go to TRAIN when pll_lock_out=1.
  - TRAIN: oe_in=1, load_word=1, d_out=TRAIN_PATTERN for exactly TRAIN_WORDS cycles. bond_sync=1 only on the first TRAIN cycle. Then go to RUN.
  - RUN: oe_in=1, load_word=1, train_done=1. Each cycle:
    - FIFO non-empty: pop the head into d_out.
    - FIFO empty: d_out=IDLE_PATTERN (underrun; no stall, no error).
- Loss of lock: pll_lock_out falling in TRAIN or RUN goes to IDLE on the next edge. The train counter clears; FIFO contents are kept. Re-lock restarts the full TRAIN sequence.
- All datapath outputs (d_out, load_word, oe_in, bond_sync, train_done) are registered.
- FIFO handshake:
  - Push when s_valid & s_ready. s_ready = (fifo_level < FIFO_DEPTH), from registered state.
  - Simultaneous push and pop: level unchanged. When full, no push is possible even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pushes are accepted in every state, including IDLE.
- Latency: a word accepted at edge N into an empty FIFO while in RUN appears on d_out at edge N+1. Words leave in strict FIFO order.
- Reset asserted mid-operation: immediate return to reset values, FIFO flushed, FSM to IDLE.

Optional Feature:
- Macro: SERDES_TX_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [7:0].
  - Increments on each RUN cycle with an empty FIFO; saturates at 255.
  - Clears on reset or on any entry to TRAIN.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, pll_lock_raw=1 at cycle 0, no traffic -> pll_lock_out high at edge 2. oe_in=1 plus 8 cycles of d_out=4'b1010 with bond_sync high only on the first. Then train_done=1 and d_out=4'b0000.
- In RUN, push 4'h3, 4'h7, 4'hC back-to-back -> d_out shows 3, 7, C on consecutive cycles, each one cycle after acceptance, then 0.
- pll_lock_raw held 0, push 5 words with s_valid held high -> 4 accepted, s_ready=0, fifo_level=4. After lock and 8 training words, d_out drains the 4 words in order.
- Drop pll_lock_raw mid-RUN -> oe_in=0 and load_word=0 within 3 edges. Re-lock -> 8 training words again, with bond_sync pulsed once.
- Assert reset during TRAIN with FIFO level 2 -> all outputs 0, fifo_level=0 immediately. After release, training restarts from word 1.
- With SERDES_TX_UNDERRUN_CNT_EN defined: 300 empty RUN cycles -> underrun_cnt=255. Relock -> underrun_cnt=0.

Source files
------------

// File: rtl/serdes_tx_word_feeder.sv
// Fabric-side feeder for the O_SERDES transmit primitive: lock sync, training burst, FIFO-backed data with idle fill.
// Optional macro SERDES_TX_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
module serdes_tx_word_feeder #(
  parameter int              WIDTH         = 4,
  parameter int              FIFO_DEPTH    = 4,
  parameter int              TRAIN_WORDS   = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'b1010,
  parameter logic [WIDTH-1:0] IDLE_PATTERN  = 4'b0000
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            pll_lock_raw,
  input  logic [WIDTH-1:0]                s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [WIDTH-1:0]                d_out,
  output logic                            load_word,
  output logic                            oe_in,
  output logic                            pll_lock_out,
  output logic                            bond_sync,
`ifdef SERDES_TX_UNDERRUN_CNT_EN
  output logic [7:0]                      underrun_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            train_done
);

  localparam int         PW         = $clog2(FIFO_DEPTH);
  localparam int         LW         = PW + 1;
  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic             lock_meta_r;
  logic             lock_sync_r;
  state_t           state_r;
  state_t           state_s;
  logic [7:0]       train_cnt_r;
  logic [7:0]       train_cnt_s;
  logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             s_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             entering_train_s;
  logic [WIDTH-1:0] d_s;
  logic             load_s;
  logic             oe_s;
  logic             bond_s;
  logic             done_s;
  logic [WIDTH-1:0] d_out_r;
  logic             load_word_r;
  logic             oe_in_r;
  logic             bond_sync_r;
  logic             train_done_r;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock_raw;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Next-state and training counter; lock loss always falls back to IDLE
  always_comb begin
    state_s     = state_r;
    train_cnt_s = train_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (lock_sync_r) begin
          state_s     = ST_TRAIN;
          train_cnt_s = 8'd1;
        end else begin
          state_s     = ST_IDLE;
          train_cnt_s = 8'd0;
        end
      end
      ST_TRAIN: begin
        if (!lock_sync_r) begin
          state_s     = ST_IDLE;
          train_cnt_s = 8'd0;
        end else if (train_cnt_r == TRAIN_LAST) begin
          state_s     = ST_RUN;
          train_cnt_s = 8'd0;
        end else begin
          state_s     = ST_TRAIN;
          train_cnt_s = train_cnt_r + 8'd1;
        end
      end
      ST_RUN: begin
        if (!lock_sync_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
        train_cnt_s = 8'd0;
      end
      default: begin
        state_s     = ST_IDLE;
        train_cnt_s = 8'd0;
      end
    endcase
  end

  assign s_ready_s        = (level_r < LW'(FIFO_DEPTH));
  assign push_s           = s_valid & s_ready_s;
  assign pop_s            = (state_s == ST_RUN) && (level_r != {LW{1'b0}});
  assign entering_train_s = (state_r != ST_TRAIN) && (state_s == ST_TRAIN);

  // Output decode from the state being entered, so the registers line up with it
  always_comb begin
    d_s    = IDLE_PATTERN;
    load_s = 1'b0;
    oe_s   = 1'b0;
    bond_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        d_s = IDLE_PATTERN;
      end
      ST_TRAIN: begin
        d_s    = TRAIN_PATTERN;
        load_s = 1'b1;
        oe_s   = 1'b1;
        bond_s = entering_train_s;
      end
      ST_RUN: begin
        load_s = 1'b1;
        oe_s   = 1'b1;
        done_s = 1'b1;
        if (pop_s) begin
          d_s = mem_r[rd_ptr_r];
        end else begin
          d_s = IDLE_PATTERN;
        end
      end
      default: begin
        d_s = IDLE_PATTERN;
      end
    endcase
  end

  // FSM state and registered primitive-facing outputs
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      train_cnt_r  <= 8'd0;
      d_out_r      <= {WIDTH{1'b0}};
      load_word_r  <= 1'b0;
      oe_in_r      <= 1'b0;
      bond_sync_r  <= 1'b0;
      train_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      train_cnt_r  <= train_cnt_s;
      d_out_r      <= d_s;
      load_word_r  <= load_s;
      oe_in_r      <= oe_s;
      bond_sync_r  <= bond_s;
      train_done_r <= done_s;
    end
  end

  // FIFO pointers and occupancy; contents survive lock loss
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

`ifdef SERDES_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_r;

  // Saturating count of idle-filled RUN cycles, cleared on each training entry
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      underrun_cnt_r <= 8'd0;
    end else if (entering_train_s) begin
      underrun_cnt_r <= 8'd0;
    end else if ((state_s == ST_RUN) && !pop_s && (underrun_cnt_r != 8'hFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 8'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_r;
`endif

  assign s_ready      = s_ready_s;
  assign fifo_level   = level_r;
  assign pll_lock_out = lock_sync_r;
  assign d_out        = d_out_r;
  assign load_word    = load_word_r;
  assign oe_in        = oe_in_r;
  assign bond_sync    = bond_sync_r;
  assign train_done   = train_done_r;

endmodule

// File: tb/tb_serdes_tx_word_feeder.sv
// Self-checking bench for serdes_tx_word_feeder: directed scenarios plus randomized traffic against a queue-based model.
module tb_serdes_tx_word_feeder;
  localparam int DEPTH = 4;
  localparam int TW    = 8;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       pll_lock_raw = 1'b0;
  logic [3:0] s_data = 4'h0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [3:0] d_out;
  logic       load_word, oe_in, pll_lock_out, bond_sync, train_done;
  logic [2:0] fifo_level;
`ifdef SERDES_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  int errors = 0;
  int checks = 0;

  serdes_tx_word_feeder dut (
    .clk_in(clk_in), .reset(reset), .pll_lock_raw(pll_lock_raw),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .d_out(d_out), .load_word(load_word), .oe_in(oe_in),
    .pll_lock_out(pll_lock_out), .bond_sync(bond_sync),
`ifdef SERDES_TX_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .fifo_level(fifo_level), .train_done(train_done)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: word queue, operating mode, lock delay line, expected outputs
  logic [3:0] mq[$];
  int         m_mode;
  int         m_trained;
  logic       m_l1, m_l0;
  logic [3:0] e_d;
  logic       e_oe, e_bond, e_done;
  int         e_ucnt;

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_trained = 0; m_l1 = 1'b0; m_l0 = 1'b0;
    e_d = 4'h0; e_oe = 1'b0; e_bond = 1'b0; e_done = 1'b0; e_ucnt = 0;
  endtask

  task automatic model_step();
    bit acc;
    bit entering;
    if (!reset) begin
      model_reset();
    end else begin
      acc = s_valid && (mq.size() < DEPTH);
      entering = 1'b0;
      if (m_mode == 0) begin
        if (m_l0) begin m_mode = 1; m_trained = 1; entering = 1'b1; end
      end else if (m_mode == 1) begin
        if (!m_l0) m_mode = 0;
        else if (m_trained == TW) m_mode = 2;
        else m_trained++;
      end else begin
        if (!m_l0) m_mode = 0;
      end
      e_oe = (m_mode != 0);
      e_done = (m_mode == 2);
      e_bond = entering;
      e_d = 4'h0;
      if (entering) e_ucnt = 0;
      if (m_mode == 1) e_d = 4'b1010;
      if (m_mode == 2) begin
        if (mq.size() > 0) e_d = mq.pop_front();
        else if (e_ucnt < 255) e_ucnt++;
      end
      if (acc) mq.push_back(s_data);
      m_l0 = m_l1;
      m_l1 = pll_lock_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset = 1'b0; s_valid = 1'b0; pll_lock_raw = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    tick();
    checks++;
    if ({d_out, load_word, oe_in, pll_lock_out, bond_sync, train_done} !== 9'd0)
      begin errors++; $display("FAIL reset_outputs: got %b expected 0", {d_out, load_word, oe_in, pll_lock_out, bond_sync, train_done}); end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    reset = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_lock_train();
    pll_lock_raw = 1'b1;
    tick();
    checks++;
    if (pll_lock_out !== 1'b0) begin errors++; $display("FAIL lock_edge1: got %b expected 0", pll_lock_out); end
    tick();
    checks++;
    if (pll_lock_out !== 1'b1 || oe_in !== 1'b0) begin errors++; $display("FAIL lock_edge2: lock=%b oe=%b expected 1/0", pll_lock_out, oe_in); end
    for (int i = 0; i < TW; i++) begin
      tick();
      checks++;
      if (oe_in !== 1'b1 || load_word !== 1'b1 || d_out !== 4'b1010 || bond_sync !== (i == 0) || train_done !== 1'b0) begin
        errors++;
        $display("FAIL train_word%0d: oe=%b load=%b d=%h bond=%b done=%b expected 1/1/a/%b/0", i, oe_in, load_word, d_out, bond_sync, train_done, (i == 0));
      end
    end
    tick();
    checks++;
    if (train_done !== 1'b1 || d_out !== 4'h0 || bond_sync !== 1'b0 || oe_in !== 1'b1) begin
      errors++; $display("FAIL run_entry: done=%b d=%h bond=%b oe=%b expected 1/0/0/1", train_done, d_out, bond_sync, oe_in);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w [3];
    w[0] = 4'h3; w[1] = 4'h7; w[2] = 4'hC;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = w[i];
      tick();
      checks++;
      if (d_out !== ((i == 0) ? 4'h0 : w[(i == 0) ? 0 : i - 1]) || fifo_level !== 3'd1) begin
        errors++; $display("FAIL b2b_step%0d: d=%h level=%0d", i, d_out, fifo_level);
      end
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (d_out !== 4'hC) begin errors++; $display("FAIL b2b_last: got %h expected c", d_out); end
    tick();
    checks++;
    if (d_out !== 4'h0 || fifo_level !== 3'd0) begin errors++; $display("FAIL b2b_idle: d=%h level=%0d expected 0/0", d_out, fifo_level); end
  endtask

  task automatic test_fill_unlocked();
    logic [3:0] words [5];
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      words[i] = 4'($urandom_range(0, 15));
      s_data = words[i];
      tick();
      checks++;
      if (s_ready !== (i < 3)) begin errors++; $display("FAIL fill_ready%0d: got %b expected %b", i, s_ready, (i < 3)); end
    end
    s_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", fifo_level); end
    pll_lock_raw = 1'b1;
    repeat (10) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (d_out !== words[k] || train_done !== 1'b1) begin errors++; $display("FAIL drain%0d: d=%h done=%b expected %h/1", k, d_out, train_done, words[k]); end
    end
    tick();
    checks++;
    if (d_out !== 4'h0 || fifo_level !== 3'd0) begin errors++; $display("FAIL drain_end: d=%h level=%0d expected 0/0", d_out, fifo_level); end
  endtask

  task automatic test_lock_loss();
    int n = 0;
    int trains = 0;
    int bonds = 0;
    pll_lock_raw = 1'b0;
    while (oe_in !== 1'b0 && n < 3) begin tick(); n++; end
    checks++;
    if (oe_in !== 1'b0 || load_word !== 1'b0) begin errors++; $display("FAIL lock_loss: oe=%b load=%b after %0d edges expected 0/0", oe_in, load_word, n); end
    repeat (2) tick();
    pll_lock_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (oe_in === 1'b1 && d_out === 4'b1010 && train_done === 1'b0) trains++;
      if (bond_sync === 1'b1) bonds++;
    end
    checks++;
    if (trains != TW || bonds != 1 || train_done !== 1'b1) begin
      errors++; $display("FAIL relock: trains=%0d bonds=%0d done=%b expected 8/1/1", trains, bonds, train_done);
    end
  endtask

  task automatic test_reset_in_train();
    int trains = 0;
    int bond_at = 0;
    do_reset();
    s_valid = 1'b1; s_data = 4'h5; tick();
    s_data = 4'h9; tick();
    s_valid = 1'b0;
    pll_lock_raw = 1'b1;
    repeat (5) tick();
    checks++;
    if (oe_in !== 1'b1 || fifo_level !== 3'd2) begin errors++; $display("FAIL pre_reset: oe=%b level=%0d expected 1/2", oe_in, fifo_level); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({d_out, load_word, oe_in, pll_lock_out, bond_sync, train_done} !== 9'd0 || fifo_level !== 3'd0) begin
      errors++; $display("FAIL mid_reset: outs=%b level=%0d expected 0/0", {d_out, load_word, oe_in, pll_lock_out, bond_sync, train_done}, fifo_level);
    end
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (oe_in === 1'b1 && d_out === 4'b1010) trains++;
      if (bond_sync === 1'b1 && bond_at == 0) bond_at = i;
    end
    checks++;
    if (trains != TW || bond_at != 3 || train_done !== 1'b1 || fifo_level !== 3'd0 || d_out !== 4'h0) begin
      errors++; $display("FAIL retrain: trains=%0d bond_at=%0d done=%b level=%0d d=%h expected 8/3/1/0/0", trains, bond_at, train_done, fifo_level, d_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    pll_lock_raw = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      s_valid = ($urandom_range(0, 99) < 55);
      s_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 2) pll_lock_raw = ~pll_lock_raw;
      if (!pll_lock_raw && $urandom_range(0, 99) < 10) pll_lock_raw = 1'b1;
      tick();
      checks++;
      if (d_out !== e_d) begin errors++; $display("FAIL rnd_d cyc%0d: got %h expected %h", c, d_out, e_d); end
      checks++;
      if (oe_in !== e_oe || load_word !== e_oe || bond_sync !== e_bond || train_done !== e_done) begin
        errors++; $display("FAIL rnd_ctrl cyc%0d: oe=%b load=%b bond=%b done=%b expected %b/%b/%b/%b", c, oe_in, load_word, bond_sync, train_done, e_oe, e_oe, e_bond, e_done);
      end
      checks++;
      if (fifo_level !== 3'(mq.size()) || s_ready !== (mq.size() < DEPTH) || pll_lock_out !== m_l0) begin
        errors++; $display("FAIL rnd_fifo cyc%0d: level=%0d ready=%b lock=%b expected %0d/%b/%b", c, fifo_level, s_ready, pll_lock_out, mq.size(), (mq.size() < DEPTH), m_l0);
      end
`ifdef SERDES_TX_UNDERRUN_CNT_EN
      checks++;
      if (underrun_cnt !== 8'(e_ucnt)) begin errors++; $display("FAIL rnd_ucnt cyc%0d: got %0d expected %0d", c, underrun_cnt, e_ucnt); end
`endif
    end
  endtask

`ifdef SERDES_TX_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    do_reset();
    pll_lock_raw = 1'b1;
    repeat (10) tick();
    repeat (300) tick();
    checks++;
    if (underrun_cnt !== 8'd255) begin errors++; $display("FAIL ucnt_sat: got %0d expected 255", underrun_cnt); end
    pll_lock_raw = 1'b0;
    repeat (4) tick();
    pll_lock_raw = 1'b1;
    repeat (3) tick();
    checks++;
    if (underrun_cnt !== 8'd0 || bond_sync !== 1'b1) begin errors++; $display("FAIL ucnt_clear: got %0d bond=%b expected 0/1", underrun_cnt, bond_sync); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_train();
    test_back_to_back();
    test_fill_unlocked();
    test_lock_loss();
    test_reset_in_train();
    test_random();
`ifdef SERDES_TX_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
